// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin sharing of one uart_tx transmitter among NUM_REQ byte producers.
// Latency: accept in cycle T, uart_tx_en pulse in T+1, next accept one cycle after busy falls.
// Backpressure: req_ready is granted one-hot only in IDLE with the transmitter idle; others wait.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 16,
  parameter int IDW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 uart_tx_en,
  output logic [7:0]           uart_tx_data,
  input  logic                 uart_tx_busy,
  output logic [IDW-1:0]       grant_id,
  output logic                 arb_busy,
  output logic                 start_err
);

  localparam int CW = $clog2(START_TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t         r_state;
  logic [IDW-1:0] r_last_grant;
  logic [IDW-1:0] r_grant_id;
  logic [7:0]     r_tx_data;
  logic           r_tx_en;
  logic           r_start_err;
  logic [CW-1:0]  r_cnt;

  logic [7:0]     w_bytes [NUM_REQ];
  logic           w_found;
  logic [IDW-1:0] w_sel;
  logic [7:0]     w_sel_byte;
  logic           w_grant;
  int             w_idx;

  // Split the flat data bus into one byte per requester.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_bytes[g] = req_data[8*g +: 8];
  end

  // Round-robin search: first valid requester starting just after the last grant.
  always_comb begin
    w_found    = 1'b0;
    w_sel      = '0;
    w_idx      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = (int'(r_last_grant) + k) % NUM_REQ;
      if (!w_found && req_valid[IDW'(w_idx)]) begin
        w_found = 1'b1;
        w_sel   = IDW'(w_idx);
      end
    end
    w_sel_byte = w_bytes[w_sel];
  end

  assign w_grant   = (r_state == S_IDLE) && !uart_tx_busy && w_found;
  // Ready is masked during reset so the reset value is 0 even with requests pending.
  assign req_ready = (w_grant && resetn) ? (NUM_REQ'(1) << w_sel) : '0;

  assign uart_tx_en   = r_tx_en;
  assign uart_tx_data = r_tx_data;
  assign grant_id     = r_grant_id;
  assign arb_busy     = (r_state != S_IDLE);
  assign start_err    = r_start_err;

  // Arbitration FSM: grant, issue start pulse, wait for busy to rise, then to fall.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_last_grant <= IDW'(NUM_REQ - 1);
      r_grant_id   <= '0;
      r_tx_data    <= 8'h00;
      r_tx_en      <= 1'b0;
      r_start_err  <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_tx_en     <= 1'b0;
      r_start_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_tx_data    <= w_sel_byte;
            r_grant_id   <= w_sel;
            r_last_grant <= w_sel;
            r_tx_en      <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          // The error pulse is already showing: the timeout is final, the byte is dropped.
          if (r_start_err) begin
            r_state <= S_IDLE;
          end else if (uart_tx_busy) begin
            r_state <= S_WAIT_DONE;
          end else begin
            if (r_cnt != CNT_LAST) begin
              r_cnt <= r_cnt + CW'(1);
            end
            if (r_cnt + CW'(1) == CNT_LAST) begin
              r_start_err <= 1'b1;
            end
          end
        end
        S_WAIT_DONE: begin
          if (!uart_tx_busy) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares a single `uart_tx` transmitter among `NUM_REQ` byte producers. Requesters use a valid/ready handshake. A round-robin arbiter grants one requester at a time, latches its byte and drives the transmitter's `uart_tx_en`/`uart_tx_data` inputs. It then tracks `uart_tx_busy` until the frame completes. The block sits between on-chip clients (debug console, status reporter, etc.) and the `uart_tx` instance, and guards against a transmitter that never acknowledges a start.

## Interface
- `NUM_REQ`, 4: number of requesters, 1..16.
- `START_TIMEOUT`, 16: cycles to wait for `uart_tx_busy` to rise after a start pulse before flagging an error, ≥2.
- `IDW`, `NUM_REQ>1 ? $clog2(NUM_REQ) : 1`: grant index width (derived; do not override).

Ports:
- `clk` in 1: system clock; all logic on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: requester i has a byte pending.
- `req_data` in 8*NUM_REQ: byte for requester i at bits [8i+7:8i].
- `req_ready` out NUM_REQ: one-hot; byte of requester i is accepted in the cycle where `req_valid[i] && req_ready[i]`.
- `uart_tx_en` out 1: single-cycle start pulse to `uart_tx`.
- `uart_tx_data` out 8: registered byte presented to `uart_tx`.
- `uart_tx_busy` in 1: transmitter busy flag from `uart_tx`.
- `grant_id` out IDW: index of the requester whose byte is in flight.
- `arb_busy` out 1: high whenever the state is not IDLE.
- `start_err` out 1: one-cycle pulse on start timeout.

## Operation
- **States:** IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- **IDLE**
  - If `uart_tx_busy`=0 and any `req_valid` is set, select the first valid requester searching from `last_grant+1` upward, with modulo NUM_REQ wrap.
  - `req_ready` for that requester is asserted combinationally in this cycle; all other bits are 0.
  - On the clock edge: `uart_tx_data` <= selected byte, `grant_id` and `last_grant` <= selected index, state -> ISSUE.
  - If `uart_tx_busy`=1 in IDLE (transmitter in use or still finishing), no grant is made.
- **ISSUE**
  - `uart_tx_en`=1 for exactly this cycle.
  - Reset the timeout counter; state -> WAIT_BUSY.
- **WAIT_BUSY**
  - If `uart_tx_busy`=1, state -> WAIT_DONE.
  - Otherwise increment the counter. When it reaches START_TIMEOUT-1, pulse `start_err` and return to IDLE. The byte is dropped, not retried.
- **WAIT_DONE**
  - When `uart_tx_busy`=0, state -> IDLE.
- `req_ready` is 0 in every state except IDLE.
- Requesters hold `req_valid` and data stable until accepted. Deasserting `req_valid` before acceptance withdraws the request without side effects.
- `uart_tx_data` and `grant_id` hold their values until the next grant.
- Counter width is `$clog2(START_TIMEOUT)+1`. The counter saturates and never wraps.

## Timing
- **Reset values:** state=IDLE, `req_ready`=0, `uart_tx_en`=0, `uart_tx_data`=8'h00, `grant_id`=0, `arb_busy`=0, `start_err`=0.
- **Reset pointer:** `last_grant`=NUM_REQ-1, so requester 0 has first priority.
- **Latency:** accept in cycle T (IDLE), `uart_tx_en` high in T+1, `arb_busy` high from T+1.
- **Back-to-back:** if `uart_tx_busy` falls in cycle T (seen in WAIT_DONE), IDLE at T+1, next accept possible at T+1, next `uart_tx_en` at T+2.
- **Simultaneous requests:** exactly one grant per frame. Rotation guarantees that every continuously valid requester is served within NUM_REQ frames.
- **NUM_REQ=1:** always grants index 0. `grant_id` is 1 bit and stays 0.
- **Reset mid-operation:** asynchronous return to the reset values. An in-flight byte is abandoned. `uart_tx_en` drops immediately.
- **Timeout:** `start_err` is asserted in the cycle the state leaves WAIT_BUSY, i.e. START_TIMEOUT cycles after the ISSUE cycle.

## Test plan
- **Single request:** after reset, `req_valid`=4'b0100 with data 8'hA5 → `req_ready`=4'b0100 in the same cycle, `uart_tx_en` pulse next cycle with `uart_tx_data`=8'hA5 and `grant_id`=2. Busy from a real `uart_tx` (BIT_RATE 9600, CLK_HZ 50 MHz) is followed to completion.
- **Round robin:** all four requesters valid continuously, data 8'h10..8'h13 → grant order 0,1,2,3,0. A `uart_txd` decoder sees 10,11,12,13,10.
- **Busy gating:** force `uart_tx_busy`=1 while in IDLE with `req_valid`=4'b0001 → `req_ready` stays 0 until busy drops. Grant follows in the first cycle busy is 0.
- **Start timeout:** stub transmitter that never asserts busy, START_TIMEOUT=16 → `start_err` pulses 16 cycles after the ISSUE cycle, state returns to IDLE, next request is served normally.
- **Withdrawal:** requester 1 raises `req_valid` while a frame is in WAIT_DONE, drops it before IDLE → no `req_ready[1]`, no transmission.
- **Reset mid-frame:** deassert `resetn` during WAIT_DONE → all outputs at reset values immediately. After release, requester 0 is prioritized over requester 3 when both are valid.
